// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program image into the 32x8 program memory,
// then releases cpu_core and runs it for a cycle budget or until halted.
module boot_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              halt_req,
    input  logic              resume,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic [DATA_W-1:0] core_mem_write_data,
    input  logic              core_mem_write,
    output logic              core_reset,
    output logic              start_execution,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic [1:0]        seq_state,
    output logic [CNT_W-1:0]  run_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    state_t              r_state;
    state_t              w_next;
    logic                w_load_go;
    logic                w_accept;
    logic                w_budget_hit;
    logic [ADDR_W:0]     w_len;

    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_count;

    assign w_len = (load_len > DEPTH) ? DEPTH : load_len;

    // Budget expires on the last permitted RUN cycle; 0 means unbounded.
    assign w_budget_hit = (run_cycles != '0) &&
                          (r_count == run_cycles - CNT_W'(1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and loader handshake decode.
    always_comb begin
        w_next    = r_state;
        w_load_go = 1'b0;
        w_accept  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_load_go = 1'b1;
                    w_next    = (w_len == '0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    w_accept = 1'b1;
                    if (r_remaining == (ADDR_W+1)'(1)) w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req || w_budget_hit) w_next = S_HALT;
            end
            S_HALT: begin
                if (load_start) begin
                    w_load_go = 1'b1;
                    w_next    = (w_len == '0) ? S_RUN : S_LOAD;
                end else if (resume) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Loader pointer, byte count and the registered one-cycle write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_remaining <= '0;
            r_ptr       <= '0;
            r_wr        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_wr <= w_accept;
            if (w_load_go) begin
                r_ptr       <= '0;
                r_remaining <= w_len;
            end else if (w_accept) begin
                r_waddr     <= r_ptr;
                r_wdata     <= load_data;
                r_ptr       <= r_ptr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
        end
    end

    // Run counter: cleared on every entry into RUN, saturating while running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_state != S_RUN && w_next == S_RUN) begin
            r_count <= '0;
        end else if (r_state == S_RUN && r_count != '1) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Memory port mux: the final loader write lands in the first RUN cycle
    // and takes priority there; the core owns the port only in RUN.
    always_comb begin
        mem_addr       = r_waddr;
        mem_write_data = r_wdata;
        mem_write      = 1'b0;
        if (r_wr) begin
            mem_write = 1'b1;
        end else if (r_state == S_RUN) begin
            mem_addr       = core_mem_addr;
            mem_write_data = core_mem_write_data;
            mem_write      = core_mem_write;
        end
    end

    assign load_ready      = (r_state == S_LOAD);
    assign core_reset      = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign start_execution = (r_state == S_RUN);
    assign seq_state       = r_state;
    assign run_count       = r_count;

endmodule

// File: tb/tb_boot_sequencer.sv
// Testbench for boot_sequencer: table-driven load vectors, hand sequences
// for run/halt corners, and a scoreboard on the memory write port.
module tb_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic [5:0]  load_len;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic [15:0] run_cycles;
    logic        halt_req;
    logic        resume;
    logic [4:0]  core_mem_addr;
    logic [7:0]  core_mem_write_data;
    logic        core_mem_write;
    logic        core_reset;
    logic        start_execution;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_write_data;
    logic        mem_write;
    logic [1:0]  seq_state;
    logic [15:0] run_count;

    int n_run  = 0;
    int n_fail = 0;

    logic [12:0] exp_q[$];

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [1:0] exp_state;
        logic       exp_wr;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t tbl[4];

    boot_sequencer dut (
        .clock               (clock),
        .reset               (reset),
        .load_start          (load_start),
        .load_len            (load_len),
        .load_valid          (load_valid),
        .load_data           (load_data),
        .load_ready          (load_ready),
        .run_cycles          (run_cycles),
        .halt_req            (halt_req),
        .resume              (resume),
        .core_mem_addr       (core_mem_addr),
        .core_mem_write_data (core_mem_write_data),
        .core_mem_write      (core_mem_write),
        .core_reset          (core_reset),
        .start_execution     (start_execution),
        .mem_addr            (mem_addr),
        .mem_write_data      (mem_write_data),
        .mem_write           (mem_write),
        .seq_state           (seq_state),
        .run_count           (run_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every memory write must match the next expected write.
    always @(negedge clock) begin
        if (reset === 1'b1 && mem_write === 1'b1) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h",
                         mem_addr, mem_write_data);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_write_data} !== e) begin
                    n_fail++;
                    $display("FAIL write: got %0h/%0h expected %0h/%0h",
                             mem_addr, mem_write_data, e[12:8], e[7:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [4:0] a, input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        chk("ready_in_load", load_ready, 1);
        exp_q.push_back({a, d});
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halted", seq_state, 3);
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 8'h11, 1'b1, 2'd1, 1'b1, 5'd0};
        tbl[1] = '{1'b0, 8'hEE, 1'b1, 2'd1, 1'b0, 5'd0};
        tbl[2] = '{1'b1, 8'h22, 1'b1, 2'd2, 1'b1, 5'd1};
        tbl[3] = '{1'b0, 8'hEE, 1'b0, 2'd2, 1'b0, 5'd0};

        reset = 1'b0; load_start = 1'b0; load_len = '0;
        load_valid = 1'b0; load_data = '0; run_cycles = '0;
        halt_req = 1'b0; resume = 1'b0; core_mem_addr = '0;
        core_mem_write_data = '0; core_mem_write = 1'b0;
        #12;
        chk("rst_state", seq_state, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_start", start_execution, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_write_data, 0);
        chk("rst_count", run_count, 0);
        reset = 1'b1;
        tick();

        // 1: three back-to-back bytes, RUN on the edge of the final write
        load_len = 6'd3; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t1_load", seq_state, 1);
        chk("t1_core_reset", core_reset, 1);
        send_byte(5'd0, 8'hA1);
        chk("t1_wr0", {mem_write, mem_addr, mem_write_data}, {1'b1, 5'd0, 8'hA1});
        chk("t1_state0", seq_state, 1);
        send_byte(5'd1, 8'hB2);
        chk("t1_wr1", {mem_write, mem_addr, mem_write_data}, {1'b1, 5'd1, 8'hB2});
        send_byte(5'd2, 8'hC3);
        chk("t1_wr2", {mem_write, mem_addr, mem_write_data}, {1'b1, 5'd2, 8'hC3});
        chk("t1_run", seq_state, 2);
        chk("t1_core_rel", core_reset, 0);
        chk("t1_start", start_execution, 1);
        chk("t1_ready_low", load_ready, 0);
        tick();
        chk("t1_wr_done", mem_write, 0);
        do_halt();
        chk("t1_halt_start", start_execution, 0);
        chk("t1_halt_core_reset", core_reset, 0);

        // 2: toggling load_valid, table-driven
        load_len = 6'd2; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = tbl[i].valid;
            load_data  = tbl[i].data;
            chk($sformatf("t2_ready%0d", i), load_ready, tbl[i].exp_ready);
            if (tbl[i].valid && load_ready)
                exp_q.push_back({tbl[i].exp_addr, tbl[i].data});
            tick();
            load_valid = 1'b0;
            chk($sformatf("t2_state%0d", i), seq_state, tbl[i].exp_state);
            chk($sformatf("t2_wr%0d", i), mem_write, tbl[i].exp_wr);
            chk($sformatf("t2_addr%0d", i), mem_addr, tbl[i].exp_addr);
        end
        do_halt();

        // 3: budget of 5 cycles
        run_cycles = 16'd5; resume = 1'b1;
        tick();
        resume = 1'b0;
        n = 0;
        while (start_execution && n < 20) begin
            n++;
            tick();
        end
        chk("t3_start_cycles", n, 5);
        chk("t3_state", seq_state, 3);
        chk("t3_count", run_count, 5);
        tick();
        chk("t3_count_hold", run_count, 5);

        // 4: unbounded run, halt on the 7th cycle, resume restarts count
        run_cycles = '0; resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("t4_count0", run_count, 0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("t4_resume_ignored", run_count, 1);
        n = 0;
        while (run_count != 16'd6 && n < 20) begin
            n++;
            tick();
        end
        chk("t4_reach6", run_count, 6);
        do_halt();
        chk("t4_count7", run_count, 7);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("t4_rerun", seq_state, 2);
        chk("t4_restart", run_count, 0);

        // 5: load_start ignored in RUN; core passthrough only in RUN
        load_len = 6'd3; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t5_ignore_start", seq_state, 2);
        chk("t5_no_ready", load_ready, 0);
        core_mem_addr = 5'd7; core_mem_write_data = 8'h5A;
        core_mem_write = 1'b1;
        exp_q.push_back({5'd7, 8'h5A});
        #1;
        chk("t5_pass", {mem_write, mem_addr, mem_write_data}, {1'b1, 5'd7, 8'h5A});
        tick();
        core_mem_write = 1'b0;
        halt_req = 1'b1;
        core_mem_write = 1'b1;
        #1;
        halt_req = 1'b1;
        exp_q.push_back({5'd7, 8'h5A});
        tick();
        halt_req = 1'b0;
        chk("t5_halt", seq_state, 3);
        chk("t5_halt_blocked", mem_write, 0);
        load_len = 6'd1; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t5_load_blocked", mem_write, 0);
        chk("t5_load_state", seq_state, 1);
        core_mem_write = 1'b0;
        send_byte(5'd0, 8'h99);
        chk("t5_len1_run", seq_state, 2);
        tick();
        do_halt();
        load_len = 6'd0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t5_len0_run", seq_state, 2);
        chk("t5_len0_count", run_count, 0);
        do_halt();

        // 6: load_start beats resume; reset mid-load; 40 clamps to 32
        load_len = 6'd4; load_start = 1'b1; resume = 1'b1;
        tick();
        load_start = 1'b0; resume = 1'b0;
        chk("t6_start_wins", seq_state, 1);
        chk("t6_core_reset", core_reset, 1);
        send_byte(5'd0, 8'h01);
        send_byte(5'd1, 8'h02);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_state", seq_state, 0);
        chk("t6_rst_wr", mem_write, 0);
        chk("t6_rst_core", core_reset, 1);
        chk("t6_rst_count", run_count, 0);
        reset = 1'b1;
        tick();
        load_len = 6'd40; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send_byte(5'(i), 8'(i) ^ 8'h5A);
            chk($sformatf("t6_state%0d", i), seq_state, (i == 31) ? 2 : 1);
        end
        chk("t6_last_addr", mem_addr, 31);
        tick();
        chk("t6_after", {seq_state, mem_write}, {2'd2, 1'b0});
        tick();
        chk("t6_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
